vdp_cmd_sequencer: RTL

ROM-driven command sequencer that replays a stored command list onto the VDP CPU-side bus (sel/rnw/addr/data with DTACK handshake). It is the parametrised successor of the fixed write-only ROM-to-VDP loader. It adds read, delay and end opcodes, a start/done handshake, configurable ROM latency and a DTACK timeout. It sits between the init-command block RAM and the VDP register port and is started by the system controller after reset.

---
 rtl/vdp_cmd_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vdp_cmd_sequencer.sv
// rtl/vdp_cmd_sequencer.sv - ROM-driven command sequencer replaying WRITE/READ/DELAY/END onto the VDP bus
module vdp_cmd_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int START_ADDR = 0,
    parameter int ROM_LAT    = 1,
    parameter int TIMEOUT    = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_rom_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [23:0]       i_rom_dout,
    input  logic [15:0]       i_vdp_do,
    input  logic              i_vdp_dtack_n,
    output logic [15:0]       o_vdp_di,
    output logic [4:0]        o_vdp_a,
    output logic              o_vdp_rnw,
    output logic              o_vdp_sel,
    output logic [15:0]       o_rd_data
);

    localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);
    localparam logic [2:0]        LAT_LAST = 3'(ROM_LAT - 1);
    localparam logic [16:0]       TO_LIMIT = 17'(TIMEOUT);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ROM_WAIT, S_ISSUE, S_BUS_WAIT, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t            r_state;
    logic [23:0]       r_cmd;
    logic [2:0]        r_lat_cnt;
    logic [15:0]       r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_rom_en;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [15:0]       r_vdp_di;
    logic [4:0]        r_vdp_a;
    logic              r_vdp_rnw;
    logic              r_vdp_sel;
    logic [15:0]       r_rd_data;

    logic [1:0]  w_op;
    logic [16:0] w_cnt_inc;
    logic        w_unused;

    assign w_op      = r_cmd[23:22];
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    // The stored rnw bit is superseded by the opcode.
    assign w_unused  = r_cmd[21];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_lat_cnt  <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= START;
            r_vdp_di   <= '0;
            r_vdp_a    <= '0;
            r_vdp_rnw  <= 1'b1;
            r_vdp_sel  <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rom_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_rom_addr <= START;
                        r_rom_en   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_lat_cnt <= '0;
                    r_state   <= S_ROM_WAIT;
                end
                S_ROM_WAIT: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_cmd   <= i_rom_dout;
                        r_state <= S_ISSUE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                S_ISSUE: begin
                    case (w_op)
                        OP_WRITE, OP_READ: begin
                            r_vdp_a   <= r_cmd[20:16];
                            r_vdp_di  <= r_cmd[15:0];
                            r_vdp_rnw <= (w_op == OP_READ);
                            r_vdp_sel <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= S_BUS_WAIT;
                        end
                        OP_DELAY: begin
                            r_cnt   <= r_cmd[15:0];
                            r_state <= S_DELAY;
                        end
                        default: begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    endcase
                end
                S_BUS_WAIT: begin
                    if (!i_vdp_dtack_n) begin
                        r_vdp_sel <= 1'b0;
                        if (w_op == OP_READ) begin
                            r_rd_data <= i_vdp_do;
                        end
                        r_rom_addr <= r_rom_addr + 1'b1;
                        r_rom_en   <= 1'b1;
                        r_state    <= S_FETCH;
                    end else if (w_cnt_inc == TO_LIMIT) begin
                        // rom_addr is left on the failing command for post-mortem.
                        r_vdp_sel <= 1'b0;
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_ERROR;
                    end else begin
                        r_cnt <= w_cnt_inc[15:0];
                    end
                end
                S_DELAY: begin
                    // A count of 0 or 1 both spend exactly one cycle here.
                    if (r_cnt <= 16'd1) begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                        r_rom_en   <= 1'b1;
                        r_state    <= S_FETCH;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_error    = r_error;
    assign o_rom_en   = r_rom_en;
    assign o_rom_addr = r_rom_addr;
    assign o_vdp_di   = r_vdp_di;
    assign o_vdp_a    = r_vdp_a;
    assign o_vdp_rnw  = r_vdp_rnw;
    assign o_vdp_sel  = r_vdp_sel;
    assign o_rd_data  = r_rd_data;

endmodule
